// File: rtl/mem_access_unit.sv
// Byte-serial load/store sequencer between the execute stage and a byte-wide data memory.
// Transfers are big-endian: the lowest address carries the most significant byte.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        LAST  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [1:0]          size_q, size_d;
    logic                sgn_q, sgn_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         asm_q, asm_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;

    logic                accept_s;
    logic                misaligned_s;
    logic [1:0]          last_idx_s;
    logic [1:0]          byte_sel_s;
    logic [31:0]         asm_shift_s;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lsb[0];
            2'b10:   bad = (lsb != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] size,
                                                input logic sgn);
        logic [31:0] res;
        case (size)
            2'b00:   res = {{24{sgn & raw[7]}}, raw[7:0]};
            2'b01:   res = {{16{sgn & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign accept_s     = req_valid && (state_q == IDLE);
    assign misaligned_s = is_misaligned(req_size, req_addr[1:0]);
    // Index of the final byte: byte 0, half 1, word 3.
    assign last_idx_s   = {size_q[1], size_q[1] | size_q[0]};
    assign byte_sel_s   = last_idx_s - cnt_q;
    assign asm_shift_s  = {asm_q[23:0], mem_rdata};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            wr_q         <= 1'b0;
            size_q       <= 2'b00;
            sgn_q        <= 1'b0;
            base_q       <= '0;
            wdata_q      <= 32'd0;
            asm_q        <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            asm_q        <= asm_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = misaligned_s ? RESP : ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (cnt_q == last_idx_s) begin
                    state_d = LAST;
                end else begin
                    state_d = ISSUE;
                end
            end
            LAST:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, byte counter, load assembly and registered response.
    always_comb begin
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        asm_d        = asm_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    cnt_d   = 2'd0;
                    wr_d    = req_wr;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    base_d  = req_addr;
                    wdata_d = req_wdata;
                    asm_d   = 32'd0;
                    if (misaligned_s) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        resp_valid_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ISSUE: begin
                if (cnt_q != last_idx_s) begin
                    cnt_d = cnt_q + 2'd1;
                end else begin
                    cnt_d = cnt_q;
                end
                // Byte issued in the previous cycle arrives now.
                if (!wr_q && (cnt_q != 2'd0)) begin
                    asm_d = asm_shift_s;
                end else begin
                    asm_d = asm_q;
                end
            end
            LAST: begin
                resp_valid_d = 1'b1;
                if (!wr_q) begin
                    asm_d        = asm_shift_s;
                    resp_rdata_d = load_extend(asm_shift_s, size_q, sgn_q);
                end else begin
                    resp_rdata_d = 32'd0;
                end
            end
            RESP:    resp_valid_d = 1'b0;
            default: resp_valid_d = 1'b0;
        endcase
    end

    // Memory-side and handshake outputs decoded from registered state.
    always_comb begin
        req_ready = (state_q == IDLE);
        mem_addr  = '0;
        mem_wdata = 8'd0;
        mem_we    = 1'b0;
        case (state_q)
            ISSUE: begin
                mem_addr = base_q + ADDR_W'(cnt_q);
                if (wr_q) begin
                    mem_wdata = wdata_q[{byte_sel_s, 3'b000} +: 8];
                    mem_we    = !rst;
                end else begin
                    mem_wdata = 8'd0;
                end
            end
            LAST:    mem_addr = base_q + ADDR_W'(cnt_q);
            default: mem_addr = '0;
        endcase
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule
